// File: rtl/counter_core.sv
// Programmable prescaled wrap-around counter with a valid/ready command port.
// Produces the count, a one-cycle terminal-count pulse and a toggle output q.
module counter_core #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] count,
  output logic             q,
  output logic             tc,
  output logic             running
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD_LIMIT    = 2'b00,
    OP_LOAD_PRESCALE = 2'b01,
    OP_START         = 2'b10,
    OP_STOP          = 2'b11
  } op_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_count, w_count_nxt;
  logic [WIDTH-1:0] r_limit, w_limit_nxt;
  logic [PRE_W-1:0] r_prescale, w_prescale_nxt;
  logic [PRE_W-1:0] r_pre, w_pre_nxt;
  logic             r_q, w_q_nxt;
  logic             r_tc, w_tc_nxt;
  logic             w_accept;
  logic             w_tick;
  logic [PRE_W-1:0] w_cmd_pre;

  assign cmd_ready = ena & ~rst;
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_tick    = (r_state == ST_RUN) && (r_pre == r_prescale);
  assign w_cmd_pre = PRE_W'(cmd_data);

  assign count   = r_count;
  assign q       = r_q;
  assign tc      = r_tc;
  assign running = (r_state == ST_RUN);

  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_limit_nxt    = r_limit;
    w_prescale_nxt = r_prescale;
    w_pre_nxt      = r_pre;
    w_q_nxt        = r_q;
    w_tc_nxt       = 1'b0;

    if (r_state == ST_RUN) begin
      if (w_tick) begin
        w_pre_nxt = '0;
        // >= so a limit lowered below the count wraps on the next tick
        if (r_count >= r_limit) begin
          w_count_nxt = '0;
          w_q_nxt     = ~r_q;
          w_tc_nxt    = 1'b1;
        end else begin
          w_count_nxt = r_count + WIDTH'(1);
        end
      end else begin
        w_pre_nxt = r_pre + PRE_W'(1);
      end
    end

    // START/STOP override any same-edge tick; loads only affect later edges
    if (w_accept) begin
      case (op_t'(cmd_op))
        OP_LOAD_LIMIT:    w_limit_nxt    = cmd_data;
        OP_LOAD_PRESCALE: w_prescale_nxt = w_cmd_pre;
        OP_START: begin
          w_state_nxt = ST_RUN;
          w_count_nxt = '0;
          w_pre_nxt   = '0;
          w_q_nxt     = r_q;
          w_tc_nxt    = 1'b0;
        end
        OP_STOP: begin
          w_state_nxt = ST_IDLE;
          w_count_nxt = r_count;
          w_pre_nxt   = r_pre;
          w_q_nxt     = r_q;
          w_tc_nxt    = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_limit    <= '1;
      r_prescale <= '0;
      r_pre      <= '0;
      r_q        <= 1'b0;
      r_tc       <= 1'b0;
    end else if (ena) begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_limit    <= w_limit_nxt;
      r_prescale <= w_prescale_nxt;
      r_pre      <= w_pre_nxt;
      r_q        <= w_q_nxt;
      r_tc       <= w_tc_nxt;
    end
  end

endmodule
